// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default geometry for the wide-to-narrow FIFO.
package fifo_pkg;

  localparam int unsigned DEF_IN_WIDTH  = 64;
  localparam int unsigned DEF_OUT_WIDTH = 8;
  localparam int unsigned RATIO         = DEF_IN_WIDTH / DEF_OUT_WIDTH;

  // $clog2 that never returns 0, so pointer/select widths stay legal.
  function automatic int unsigned clog2_safe(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  localparam int unsigned LOG2_RATIO = clog2_safe(RATIO);

  typedef logic [DEF_OUT_WIDTH-1:0] slice_arr_t [RATIO];

endpackage

// File: rtl/wtn_fifo_ram.sv
// Word storage: synchronous write port, asynchronous read port.
module wtn_fifo_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wide_to_narrow_fifo.sv
// Single-clock FIFO taking wide words and emitting narrow elements on a
// registered valid/strobe interface, with fill level and sticky error flags.
module wide_to_narrow_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ROOM_WORDS = 2,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic                                            flush,
  input  logic [IN_WIDTH-1:0]                             wdata,
  input  logic                                            we,
  output logic                                            room,
  input  logic                                            strobe,
  output logic                                            valid,
  output logic [OUT_WIDTH-1:0]                            q,
  output logic [$clog2(DEPTH*(IN_WIDTH/OUT_WIDTH)):0]     level,
  output logic                                            overflow,
  output logic                                            underflow
);

  localparam int unsigned N_ELEM    = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned ELEM_LOG2 = clog2_safe(N_ELEM);
  localparam int unsigned ADDR_W    = clog2_safe(DEPTH);
  localparam int unsigned WPTR_W    = ADDR_W + 1;
  localparam int unsigned RPTR_W    = ADDR_W + ELEM_LOG2 + 1;

  if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_err_width
    $error("IN_WIDTH must be a multiple of OUT_WIDTH");
  end
  if (N_ELEM < 2 || (N_ELEM & (N_ELEM - 1)) != 0) begin : g_err_ratio
    $error("IN_WIDTH/OUT_WIDTH must be a power of two >= 2");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_err_depth
    $error("DEPTH must be a power of two >= 4");
  end
  if (ROOM_WORDS < 1 || ROOM_WORDS > DEPTH) begin : g_err_room
    $error("ROOM_WORDS must lie in 1..DEPTH");
  end

  typedef logic [OUT_WIDTH-1:0] slices_t [N_ELEM];

  logic [WPTR_W-1:0]    wptr, wptr_nxt;
  logic [RPTR_W-1:0]    rptr, rptr_nxt;
  logic                 valid_nxt, overflow_nxt, underflow_nxt;
  logic [OUT_WIDTH-1:0] q_nxt;
  logic [RPTR_W-1:0]    pending;
  logic [WPTR_W-1:0]    free_words;
  logic                 ram_we;
  logic [IN_WIDTH-1:0]  rd_word;
  logic [ELEM_LOG2-1:0] elem_sel;
  slices_t              slices;

  // Occupancy: a word slot stays busy until its last element has entered q.
  assign pending    = {wptr, {ELEM_LOG2{1'b0}}} - rptr;
  assign free_words = WPTR_W'(DEPTH) - (wptr - rptr[RPTR_W-1 -: WPTR_W]);
  assign level      = pending + RPTR_W'(valid);
  assign room       = (free_words >= WPTR_W'(ROOM_WORDS));
  assign ram_we     = we && !flush && (free_words != '0);

  wtn_fifo_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (IN_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (wdata),
    .raddr (rptr[RPTR_W-2 -: ADDR_W]),
    .rdata (rd_word)
  );

  // Element select; MSB-first order simply inverts the index within the word.
  always_comb begin
    for (int i = 0; i < int'(N_ELEM); i++) slices[i] = rd_word[i*OUT_WIDTH +: OUT_WIDTH];
    elem_sel = MSB_FIRST ? ~rptr[ELEM_LOG2-1:0] : rptr[ELEM_LOG2-1:0];
  end

  always_comb begin
    wptr_nxt      = wptr;
    rptr_nxt      = rptr;
    valid_nxt     = valid;
    q_nxt         = q;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    if (flush) begin
      wptr_nxt      = '0;
      rptr_nxt      = '0;
      valid_nxt     = 1'b0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else begin
      if (we) begin
        if (free_words != '0) wptr_nxt = wptr + WPTR_W'(1);
        else                  overflow_nxt = 1'b1;
      end
      if (!valid || strobe) begin
        if (pending != '0) begin
          q_nxt     = slices[elem_sel];
          valid_nxt = 1'b1;
          rptr_nxt  = rptr + RPTR_W'(1);
        end else begin
          valid_nxt = 1'b0;
        end
      end
      if (strobe && !valid) underflow_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr      <= '0;
      rptr      <= '0;
      valid     <= 1'b0;
      q         <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      valid     <= valid_nxt;
      q         <= q_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_wide_to_narrow_fifo.sv
// Directed bench for wide_to_narrow_fifo (default geometry, both element orders).
module tb_wide_to_narrow_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [63:0] wdata;
  logic        we;
  logic        strobe;

  logic        room, valid, overflow, underflow;
  logic [7:0]  q;
  logic [9:0]  level;
  logic        room_m, valid_m, overflow_m, underflow_m;
  logic [7:0]  q_m;
  logic [9:0]  level_m;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;

  wide_to_narrow_fifo #(.MSB_FIRST(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wdata(wdata), .we(we),
    .room(room), .strobe(strobe), .valid(valid), .q(q), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  wide_to_narrow_fifo #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wdata(wdata), .we(we),
    .room(room_m), .strobe(strobe), .valid(valid_m), .q(q_m), .level(level_m),
    .overflow(overflow_m), .underflow(underflow_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word wi carries bytes wi*8 .. wi*8+7, so the element stream is a byte counter.
  function automatic logic [63:0] word_of(input int unsigned wi);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(wi * 8 + j);
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned wi;
    int unsigned n;

    reset_n = 1'b0; flush = 1'b0; we = 1'b0; strobe = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_q", q, 0);
    check("rst_level", level, 0);
    check("rst_room", room, 1);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    check("rst_m_valid", valid_m, 0);
    check("rst_m_room", room_m, 1);
    check("rst_m_flags", {overflow_m, underflow_m}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic latency and element order, both orders
    we = 1'b1; wdata = 64'h0807_0605_0403_0201;
    tick();
    we = 1'b0;
    check("lat_valid_n", valid, 0);
    check("lat_level_n", level, 8);
    tick();
    check("lat_valid", valid, 1);
    check("lat_q", q, 8'h01);
    check("lat_level", level, 8);
    check("lat_q_msb", q_m, 8'h08);
    check("lat_level_msb", level_m, 8);
    strobe = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      tick();
      check("seq_q", q, 64'(k));
      check("seq_q_msb", q_m, 64'(9 - k));
    end
    tick();
    strobe = 1'b0;
    check("drain_valid", valid, 0);
    check("drain_level", level, 0);
    check("drain_valid_msb", valid_m, 0);
    check("drain_unf", underflow, 0);

    // Fill to capacity with no strobe
    for (int i = 0; i < 64; i++) begin
      we = 1'b1; wdata = word_of(i);
      tick();
      if (i == 61) check("room_at_2", room, 1);
      if (i == 62) check("room_at_1", room, 0);
    end
    check("full_level", level, 512);
    check("full_room", room, 0);
    check("full_ovf_n", overflow, 0);
    wdata = JUNK;
    tick();
    we = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_level", level, 512);
    check("ovf_q", q, 8'h00);

    // Full FIFO: write+strobe together; space appears only once word 0 is drained
    strobe = 1'b1;
    for (int c = 0; c < 8; c++) begin
      we = 1'b1;
      wdata = (c == 7) ? word_of(64) : JUNK;
      tick();
      if (c == 0) check("win_drop_level", level, 511);
      check("win_q", q, 64'(c + 1));
    end
    we = 1'b0;
    check("win_level", level, 512);
    check("win_room", room, 0);
    check("win_ovf", overflow, 1);

    // Stream across pointer wrap, writing whenever room allows
    wi = 65;
    n  = 8;
    while (n < 1599) begin
      we = room && (wi < 200);
      wdata = word_of(wi);
      tick();
      if (we) wi++;
      n++;
      check("stream_q", q, 64'(8'(n)));
    end
    we = 1'b0;
    check("stream_words", 64'(wi), 200);
    tick();
    check("end_valid", valid, 0);
    check("end_level", level, 0);
    check("end_unf", underflow, 0);
    tick();
    strobe = 1'b0;
    check("unf_set", underflow, 1);
    check("unf_valid", valid, 0);

    // Read pointer must not have moved on the ignored strobe
    we = 1'b1; wdata = 64'hF7F6_F5F4_F3F2_F1F0;
    tick();
    we = 1'b0;
    check("post_unf_valid_n", valid, 0);
    tick();
    check("post_unf_valid", valid, 1);
    check("post_unf_q", q, 8'hF0);
    check("post_unf_level", level, 8);

    // Flush clears state in one edge but holds q
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", valid, 0);
    check("flush_level", level, 0);
    check("flush_room", room, 1);
    check("flush_flags", {overflow, underflow}, 0);
    check("flush_q_hold", q, 8'hF0);
    we = 1'b1; wdata = 64'h1716_1514_1312_1110;
    tick();
    we = 1'b0;
    check("pf_valid_n", valid, 0);
    tick();
    check("pf_valid", valid, 1);
    check("pf_q", q, 8'h10);

    // Asynchronous reset between edges
    strobe = 1'b1;
    tick();
    check("pre_rst_q1", q, 8'h11);
    tick();
    check("pre_rst_q2", q, 8'h12);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_q", q, 0);
    check("arst_level", level, 0);
    check("arst_room", room, 1);
    strobe = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    we = 1'b1; wdata = 64'h2726_2524_2322_2120;
    tick();
    we = 1'b0;
    check("rr_valid_n", valid, 0);
    tick();
    check("rr_valid", valid, 1);
    check("rr_q", q, 8'h20);
    check("rr_q_msb", q_m, 8'h27);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
